ai_master_rd_dispatcher: RTL and testbench
==========================================

# ai_master_rd_dispatcher

Per-master read-side dispatcher of the AXI4 interconnect, on the master-facing end opposite the per-slave arbitration blocks. It accepts one master's AR requests and buffers them in a 2-entry skid buffer. It decodes the target slave from the address, forwards each request to that slave's arbitration port, and records issue order in an outstanding FIFO. It returns R beats to the master strictly in issue order, which preserves AXI same-ID ordering across slaves with different latencies.

## Interface
Parameters:
- SLV_AMT, 2, number of slave ports; must be a power of two.
- OUTSTANDING_AMT, 8, depth of the order FIFO, which is the maximum number of in-flight reads.
- DATA_WIDTH, 32, RDATA width.
- ADDR_WIDTH, 32, ARADDR width.
- TRANS_MST_ID_W, 5, ARID/RID width.
- TRANS_BURST_W, 2, ARBURST width.
- TRANS_DATA_LEN_W, 3, ARLEN width.
- TRANS_DATA_SIZE_W, 3, ARSIZE width.
- TRANS_WR_RESP_W, 2, RRESP width.
- SLV_ID_MSB_IDX, 30, MSB of the slave-select field in ARADDR.
- SLV_ID_LSB_IDX, 30, LSB of the slave-select field. Field width (MSB-LSB+1) must equal $clog2(SLV_AMT); a simulation assertion checks this.

Ports:
- ACLK_i  in  1  clock, single clock domain.
- ARESETn_i  in  1  asynchronous active-low reset.
- m_ARID_i / m_ARADDR_i / m_ARBURST_i / m_ARLEN_i / m_ARSIZE_i  in  param widths  master AR payload.
- m_ARVALID_i  in  1.  m_ARREADY_o  out  1.
- m_RID_o / m_RDATA_o / m_RRESP_o  out  param widths.  m_RLAST_o, m_RVALID_o  out  1.  m_RREADY_i  in  1.
- sa_ARID_o / sa_ARADDR_o / sa_ARBURST_o / sa_ARLEN_o / sa_ARSIZE_o  out  width×SLV_AMT  AR payload broadcast to every slave slot, slot s at [s*W +: W].
- sa_ARVALID_o  out  SLV_AMT.  sa_ARREADY_i  in  SLV_AMT.
- sa_AR_outst_full_o  out  SLV_AMT  order FIFO full, replicated per slave.
- sa_RID_i / sa_RDATA_i / sa_RRESP_i  in  width×SLV_AMT.  sa_RLAST_i, sa_RVALID_i  in  SLV_AMT.
- sa_RREADY_o  out  SLV_AMT.

## Operation
- **Skid buffer**
  - 2-entry FIFO of {ID, ADDR, BURST, LEN, SIZE}.
  - Push on m_ARVALID_i & m_ARREADY_o.
  - m_ARREADY_o = (skid_cnt != 2), decoded from flops only.
- **Decode**
  - sel = head.ARADDR[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX].
  - Head payload drives all sa_AR*_o slots unchanged. ID is not widened here.
- **Issue**
  - sa_ARVALID_o[sel] = skid_nonempty & !ord_full; all other bits are 0.
  - Handshake on sa_ARVALID_o[sel] & sa_ARREADY_i[sel]. On handshake: pop skid, push sel into the order FIFO.
- **Order FIFO**
  - OUTSTANDING_AMT entries of $clog2(SLV_AMT) bits, with wrap-around pointers and a count of $clog2(OUTSTANDING_AMT)+1 bits.
  - ord_full = (count == OUTSTANDING_AMT).
  - sa_AR_outst_full_o = {SLV_AMT{ord_full}}.
- **Return path** (h = order FIFO head):
  - m_RVALID_o = !ord_empty & sa_RVALID_i[h]. m_R*_o are muxed from slot h.
  - sa_RREADY_o[h] = !ord_empty & m_RREADY_i; all other bits are 0. Beats from non-head slaves are held off.
  - Pop the order FIFO on m_RVALID_o & m_RREADY_i & m_RLAST_o.
- **Simultaneous events**
  - Push and pop in the same cycle: count unchanged.
  - At ord_full, issue is blocked even if a pop occurs that cycle; the issue happens the following cycle.
  - Skid push and pop in the same cycle at skid_cnt=2 cannot occur, because ready is 0.

## Timing
- Reset values (asynchronous, immediate):
  - Skid and order FIFOs empty, pointers 0.
  - m_ARREADY_o=1.
  - sa_ARVALID_o=0, sa_AR_outst_full_o=0, m_RVALID_o=0, sa_RREADY_o=0.
  - Payload outputs are don't-care but driven from reset-zero flops.
- Reset mid-operation discards all buffered and outstanding state; in-flight slave responses are not tracked.
- AR latency: a request accepted at edge N presents sa_ARVALID_o at cycle N+1. Sustained throughput is 1 AR/cycle while sa_ARREADY_i is high.
- R path is combinational, with 0-cycle latency slave→master. Sustained throughput is 1 beat/cycle.
- sa_ARVALID_o stays asserted with stable payload until its handshake. It can only drop if ord_full rises, which cannot happen while the slot waits, because count changes only on issue and pop.

## Test plan
- Single read: ID=3, ADDR=0x0000_1000, LEN=0, held at cycle 0.
  - Required: sa_ARVALID_o=2'b01 at cycle 1 with sa_ARID slot0=3.
  - Slave0 then returns RID=3, RDATA=0xA5A5_A5A5, RLAST=1 → the master sees identical values the same cycle, and the order FIFO goes empty.
- Reordering guard: issue to slave1 (ADDR=0x4000_0000), then to slave0.
  - Slave0 raises RVALID first → sa_RREADY_o[0]=0 and m_RVALID_o=0.
  - Slave1 then returns a LEN=1 burst → both slave1 beats reach the master first, then slave0 data.
- Outstanding limit: 8 reads to slave0 accepted with no R.
  - 9th read: sa_ARVALID_o stays 0 and sa_AR_outst_full_o=2'b11.
  - After one RLAST handshake, the 9th is issued on the next cycle.
- AR backpressure: with sa_ARREADY_i=0, two requests are accepted, then m_ARREADY_o=0. Raising sa_ARREADY_i drains both in consecutive cycles in order.
- Burst with stalls: LEN=3 with m_RREADY_i toggling 1,0,1,0… → exactly 4 beats transfer, and the order FIFO pops only on the RLAST beat.
- Reset mid-burst: assert ARESETn_i low during beat 2 → outputs take their reset values immediately. After release, a new read to slave1 behaves as in the single-read case.

Source files
------------

// File: rtl/ai_master_rd_dispatcher.sv
// rtl/ai_master_rd_dispatcher.sv - per-master AR skid/decode/issue with in-order R return
module ai_master_rd_dispatcher #(
  parameter int SLV_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int TRANS_WR_RESP_W   = 2,
  parameter int SLV_ID_MSB_IDX    = 30,
  parameter int SLV_ID_LSB_IDX    = 30
) (
  input  logic                                    ACLK_i,
  input  logic                                    ARESETn_i,
  input  logic [TRANS_MST_ID_W-1:0]               m_ARID_i,
  input  logic [ADDR_WIDTH-1:0]                   m_ARADDR_i,
  input  logic [TRANS_BURST_W-1:0]                m_ARBURST_i,
  input  logic [TRANS_DATA_LEN_W-1:0]             m_ARLEN_i,
  input  logic [TRANS_DATA_SIZE_W-1:0]            m_ARSIZE_i,
  input  logic                                    m_ARVALID_i,
  output logic                                    m_ARREADY_o,
  output logic [TRANS_MST_ID_W-1:0]               m_RID_o,
  output logic [DATA_WIDTH-1:0]                   m_RDATA_o,
  output logic [TRANS_WR_RESP_W-1:0]              m_RRESP_o,
  output logic                                    m_RLAST_o,
  output logic                                    m_RVALID_o,
  input  logic                                    m_RREADY_i,
  output logic [TRANS_MST_ID_W*SLV_AMT-1:0]       sa_ARID_o,
  output logic [ADDR_WIDTH*SLV_AMT-1:0]           sa_ARADDR_o,
  output logic [TRANS_BURST_W*SLV_AMT-1:0]        sa_ARBURST_o,
  output logic [TRANS_DATA_LEN_W*SLV_AMT-1:0]     sa_ARLEN_o,
  output logic [TRANS_DATA_SIZE_W*SLV_AMT-1:0]    sa_ARSIZE_o,
  output logic [SLV_AMT-1:0]                      sa_ARVALID_o,
  input  logic [SLV_AMT-1:0]                      sa_ARREADY_i,
  output logic [SLV_AMT-1:0]                      sa_AR_outst_full_o,
  input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]       sa_RID_i,
  input  logic [DATA_WIDTH*SLV_AMT-1:0]           sa_RDATA_i,
  input  logic [TRANS_WR_RESP_W*SLV_AMT-1:0]      sa_RRESP_i,
  input  logic [SLV_AMT-1:0]                      sa_RLAST_i,
  input  logic [SLV_AMT-1:0]                      sa_RVALID_i,
  output logic [SLV_AMT-1:0]                      sa_RREADY_o
);

  localparam int SEL_W  = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1;
  localparam int OPTR_W = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
  localparam int CNT_W  = OPTR_W + 1;
  localparam int PAY_W  = TRANS_MST_ID_W + ADDR_WIDTH + TRANS_BURST_W
                        + TRANS_DATA_LEN_W + TRANS_DATA_SIZE_W;
  localparam logic [CNT_W-1:0]  ORD_FULL_CNT = CNT_W'(OUTSTANDING_AMT);
  localparam logic [OPTR_W-1:0] ORD_LAST_PTR = OPTR_W'(OUTSTANDING_AMT - 1);

  if (SLV_ID_MSB_IDX - SLV_ID_LSB_IDX + 1 != $clog2(SLV_AMT)) begin : g_sel_width_check
    $error("slave-select field width must equal clog2(SLV_AMT)");
  end

  logic [PAY_W-1:0]             skid_mem [2];
  logic                         skid_wr, skid_rd;
  logic [1:0]                   skid_cnt;
  logic                         skid_push;
  logic [PAY_W-1:0]             head;
  logic [TRANS_MST_ID_W-1:0]    head_id;
  logic [ADDR_WIDTH-1:0]        head_addr;
  logic [TRANS_BURST_W-1:0]     head_burst;
  logic [TRANS_DATA_LEN_W-1:0]  head_len;
  logic [TRANS_DATA_SIZE_W-1:0] head_size;
  logic [SEL_W-1:0]             sel;
  logic                         issue_valid, issue_hs;

  logic [SEL_W-1:0]             ord_mem [OUTSTANDING_AMT];
  logic [OPTR_W-1:0]            ord_wr, ord_rd;
  logic [CNT_W-1:0]             ord_cnt;
  logic                         ord_full, ord_empty, ord_pop;
  logic [SEL_W-1:0]             ord_head;

  function automatic logic [OPTR_W-1:0] ord_next(input logic [OPTR_W-1:0] p);
    return (p == ORD_LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign m_ARREADY_o = (skid_cnt != 2'd2);
  assign skid_push   = m_ARVALID_i & m_ARREADY_o;
  assign head        = skid_mem[skid_rd];
  assign {head_id, head_addr, head_burst, head_len, head_size} = head;
  assign sel         = head_addr[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];

  assign ord_full    = (ord_cnt == ORD_FULL_CNT);
  assign ord_empty   = (ord_cnt == '0);
  assign ord_head    = ord_mem[ord_rd];
  // Blocking on the registered full flag keeps issue a cycle behind a pop at full.
  assign issue_valid = (skid_cnt != 2'd0) & ~ord_full;
  assign issue_hs    = issue_valid & sa_ARREADY_i[sel];

  assign sa_ARID_o          = {SLV_AMT{head_id}};
  assign sa_ARADDR_o        = {SLV_AMT{head_addr}};
  assign sa_ARBURST_o       = {SLV_AMT{head_burst}};
  assign sa_ARLEN_o         = {SLV_AMT{head_len}};
  assign sa_ARSIZE_o        = {SLV_AMT{head_size}};
  assign sa_AR_outst_full_o = {SLV_AMT{ord_full}};

  assign m_RID_o    = sa_RID_i[ord_head*TRANS_MST_ID_W +: TRANS_MST_ID_W];
  assign m_RDATA_o  = sa_RDATA_i[ord_head*DATA_WIDTH +: DATA_WIDTH];
  assign m_RRESP_o  = sa_RRESP_i[ord_head*TRANS_WR_RESP_W +: TRANS_WR_RESP_W];
  assign m_RLAST_o  = sa_RLAST_i[ord_head];
  assign m_RVALID_o = ~ord_empty & sa_RVALID_i[ord_head];
  assign ord_pop    = m_RVALID_o & m_RREADY_i & m_RLAST_o;

  always_comb begin
    sa_ARVALID_o           = '0;
    sa_ARVALID_o[sel]      = issue_valid;
    sa_RREADY_o            = '0;
    sa_RREADY_o[ord_head]  = ~ord_empty & m_RREADY_i;
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      for (int i = 0; i < 2; i++) skid_mem[i] <= '0;
      skid_wr  <= 1'b0;
      skid_rd  <= 1'b0;
      skid_cnt <= 2'd0;
    end else begin
      if (skid_push) begin
        skid_mem[skid_wr] <= {m_ARID_i, m_ARADDR_i, m_ARBURST_i, m_ARLEN_i, m_ARSIZE_i};
        skid_wr           <= ~skid_wr;
      end
      if (issue_hs) skid_rd <= ~skid_rd;
      case ({skid_push, issue_hs})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: skid_cnt <= skid_cnt;
      endcase
    end
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      for (int i = 0; i < OUTSTANDING_AMT; i++) ord_mem[i] <= '0;
      ord_wr  <= '0;
      ord_rd  <= '0;
      ord_cnt <= '0;
    end else begin
      if (issue_hs) begin
        ord_mem[ord_wr] <= sel;
        ord_wr          <= ord_next(ord_wr);
      end
      if (ord_pop) ord_rd <= ord_next(ord_rd);
      case ({issue_hs, ord_pop})
        2'b10:   ord_cnt <= ord_cnt + 1'b1;
        2'b01:   ord_cnt <= ord_cnt - 1'b1;
        default: ord_cnt <= ord_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ai_master_rd_dispatcher.sv
// tb/tb_ai_master_rd_dispatcher.sv - randomized bench with queue-based ordering model
module tb_ai_master_rd_dispatcher;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [2:0]  len;
    logic [2:0]  size;
  } req_t;

  logic        ACLK_i = 1'b0;
  logic        ARESETn_i = 1'b0;
  logic [4:0]  m_ARID_i = '0;
  logic [31:0] m_ARADDR_i = '0;
  logic [1:0]  m_ARBURST_i = '0;
  logic [2:0]  m_ARLEN_i = '0;
  logic [2:0]  m_ARSIZE_i = '0;
  logic        m_ARVALID_i = 1'b0;
  logic        m_ARREADY_o;
  logic [4:0]  m_RID_o;
  logic [31:0] m_RDATA_o;
  logic [1:0]  m_RRESP_o;
  logic        m_RLAST_o, m_RVALID_o;
  logic        m_RREADY_i = 1'b0;
  logic [9:0]  sa_ARID_o;
  logic [63:0] sa_ARADDR_o;
  logic [3:0]  sa_ARBURST_o;
  logic [5:0]  sa_ARLEN_o, sa_ARSIZE_o;
  logic [1:0]  sa_ARVALID_o;
  logic [1:0]  sa_ARREADY_i = '0;
  logic [1:0]  sa_AR_outst_full_o;
  logic [9:0]  sa_RID_i = '0;
  logic [63:0] sa_RDATA_i = '0;
  logic [3:0]  sa_RRESP_i = '0;
  logic [1:0]  sa_RLAST_i = '0, sa_RVALID_i = '0;
  logic [1:0]  sa_RREADY_o;

  ai_master_rd_dispatcher dut (
    .ACLK_i(ACLK_i), .ARESETn_i(ARESETn_i),
    .m_ARID_i(m_ARID_i), .m_ARADDR_i(m_ARADDR_i), .m_ARBURST_i(m_ARBURST_i),
    .m_ARLEN_i(m_ARLEN_i), .m_ARSIZE_i(m_ARSIZE_i), .m_ARVALID_i(m_ARVALID_i),
    .m_ARREADY_o(m_ARREADY_o), .m_RID_o(m_RID_o), .m_RDATA_o(m_RDATA_o),
    .m_RRESP_o(m_RRESP_o), .m_RLAST_o(m_RLAST_o), .m_RVALID_o(m_RVALID_o),
    .m_RREADY_i(m_RREADY_i), .sa_ARID_o(sa_ARID_o), .sa_ARADDR_o(sa_ARADDR_o),
    .sa_ARBURST_o(sa_ARBURST_o), .sa_ARLEN_o(sa_ARLEN_o), .sa_ARSIZE_o(sa_ARSIZE_o),
    .sa_ARVALID_o(sa_ARVALID_o), .sa_ARREADY_i(sa_ARREADY_i),
    .sa_AR_outst_full_o(sa_AR_outst_full_o), .sa_RID_i(sa_RID_i),
    .sa_RDATA_i(sa_RDATA_i), .sa_RRESP_i(sa_RRESP_i), .sa_RLAST_i(sa_RLAST_i),
    .sa_RVALID_i(sa_RVALID_i), .sa_RREADY_o(sa_RREADY_o)
  );

  always #5 ACLK_i = ~ACLK_i;

  int   n_checks = 0, n_fail = 0;
  int   p_arv = 0, p_ardy = 100, p_rvld = 100, p_rrdy = 100;
  bit   rand_en = 1'b0;
  req_t dir_q[$], iss_q[$], outst_q[$];
  req_t slv_q[2][$];
  int   slv_beat[2];
  bit   slv_vld[2];
  int   m_beat = 0;
  req_t mreq;
  bit   mreq_vld = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.id = 5'($urandom); r.addr = $urandom; r.burst = 2'($urandom);
    r.len = 3'($urandom_range(0, 3)); r.size = 3'($urandom);
    return r;
  endfunction

  function automatic logic [31:0] beat_data(input req_t r, input int b);
    return r.addr ^ 32'hA5A5_A5A5 ^ (32'(b) * 32'h0101_0101);
  endfunction

  function automatic logic [1:0] beat_resp(input req_t r, input int b);
    return 2'(b) ^ r.burst;
  endfunction

  task automatic clear_model();
    iss_q.delete(); outst_q.delete(); dir_q.delete();
    for (int s = 0; s < 2; s++) begin
      slv_q[s].delete(); slv_beat[s] = 0; slv_vld[s] = 1'b0;
    end
    m_beat = 0; mreq_vld = 1'b0;
    m_ARVALID_i = 1'b0; sa_RVALID_i = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arready"}, m_ARREADY_o, 1'b1);
    check({tag, "_sa_arvalid"}, sa_ARVALID_o, 2'b00);
    check({tag, "_outst_full"}, sa_AR_outst_full_o, 2'b00);
    check({tag, "_rvalid"}, m_RVALID_o, 1'b0);
    check({tag, "_sa_rready"}, sa_RREADY_o, 2'b00);
  endtask

  // One clock: drive at negedge, compare model expectations, then advance model and slaves.
  task automatic cycle();
    req_t       hd, pay;
    logic [1:0] e_arv, e_rrdy;
    logic       e_rv;
    @(negedge ACLK_i);
    if (!mreq_vld) begin
      if (dir_q.size() > 0) begin
        mreq = dir_q.pop_front(); mreq_vld = 1'b1;
      end else if (rand_en && $urandom_range(0, 99) < p_arv) begin
        mreq = rand_req(); mreq_vld = 1'b1;
      end
    end
    m_ARVALID_i = mreq_vld;
    {m_ARID_i, m_ARADDR_i, m_ARBURST_i, m_ARLEN_i, m_ARSIZE_i} = mreq;
    for (int s = 0; s < 2; s++) sa_ARREADY_i[s] = ($urandom_range(0, 99) < p_ardy);
    m_RREADY_i = ($urandom_range(0, 99) < p_rrdy);
    for (int s = 0; s < 2; s++) begin
      if (!slv_vld[s] && slv_q[s].size() > 0 && $urandom_range(0, 99) < p_rvld) slv_vld[s] = 1'b1;
      sa_RVALID_i[s] = slv_vld[s];
      if (slv_q[s].size() > 0) begin
        hd = slv_q[s][0];
        sa_RID_i[s*5 +: 5]    = hd.id;
        sa_RDATA_i[s*32 +: 32] = beat_data(hd, slv_beat[s]);
        sa_RRESP_i[s*2 +: 2]  = beat_resp(hd, slv_beat[s]);
        sa_RLAST_i[s]         = (slv_beat[s] == int'(hd.len));
      end else begin
        sa_RID_i[s*5 +: 5] = 5'($urandom); sa_RDATA_i[s*32 +: 32] = $urandom;
        sa_RRESP_i[s*2 +: 2] = 2'($urandom); sa_RLAST_i[s] = 1'($urandom);
      end
    end
    #1;
    check("m_arready", m_ARREADY_o, iss_q.size() != 2);
    e_arv = 2'b00;
    if (iss_q.size() > 0 && outst_q.size() < 8) e_arv[iss_q[0].addr[30]] = 1'b1;
    check("sa_arvalid", sa_ARVALID_o, e_arv);
    check("outst_full", sa_AR_outst_full_o, (outst_q.size() == 8) ? 2'b11 : 2'b00);
    e_rrdy = 2'b00; e_rv = 1'b0;
    if (outst_q.size() > 0) begin
      hd = outst_q[0];
      e_rv = slv_vld[hd.addr[30]];
      if (m_RREADY_i) e_rrdy[hd.addr[30]] = 1'b1;
    end
    check("m_rvalid", m_RVALID_o, e_rv);
    check("sa_rready", sa_RREADY_o, e_rrdy);
    if (m_RVALID_o && m_RREADY_i && outst_q.size() > 0) begin
      hd = outst_q[0];
      check("m_rid", m_RID_o, hd.id);
      check("m_rdata", m_RDATA_o, beat_data(hd, m_beat));
      check("m_rresp", m_RRESP_o, beat_resp(hd, m_beat));
      check("m_rlast", m_RLAST_o, m_beat == int'(hd.len));
      if (m_beat == int'(hd.len)) begin
        void'(outst_q.pop_front()); m_beat = 0;
      end else m_beat++;
    end
    for (int s = 0; s < 2; s++) begin
      if (slv_vld[s] && sa_RREADY_o[s] && slv_q[s].size() > 0) begin
        slv_vld[s] = 1'b0;
        if (slv_beat[s] == int'(slv_q[s][0].len)) begin
          void'(slv_q[s].pop_front()); slv_beat[s] = 0;
        end else slv_beat[s]++;
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (sa_ARVALID_o[s] && sa_ARREADY_i[s]) begin
        pay = {sa_ARID_o[s*5 +: 5], sa_ARADDR_o[s*32 +: 32], sa_ARBURST_o[s*2 +: 2],
               sa_ARLEN_o[s*3 +: 3], sa_ARSIZE_o[s*3 +: 3]};
        slv_q[s].push_back(pay);
        if (iss_q.size() > 0) begin
          check("ar_payload", pay, iss_q[0]);
          check("ar_slot", s, iss_q[0].addr[30]);
          outst_q.push_back(iss_q.pop_front());
        end
      end
    end
    if (m_ARVALID_i && m_ARREADY_o) begin
      iss_q.push_back(mreq); mreq_vld = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    rand_en = 1'b0; p_ardy = 100; p_rvld = 100; p_rrdy = 100;
    for (int i = 0; i < 300 && (mreq_vld || dir_q.size() + iss_q.size() + outst_q.size() > 0); i++)
      cycle();
    check(tag, mreq_vld + dir_q.size() + iss_q.size() + outst_q.size(), 0);
  endtask

  initial begin
    #2;
    check_reset_outputs("por");
    @(negedge ACLK_i);
    ARESETn_i = 1'b1;

    dir_q.push_back('{id: 5'd3, addr: 32'h0000_1000, burst: 2'd1, len: 3'd0, size: 3'd2});
    repeat (6) cycle();
    drain("single_drain");

    rand_en = 1'b1; p_arv = 100; p_ardy = 100; p_rvld = 0; p_rrdy = 100;
    repeat (30) cycle();
    check("outst_reached_full", outst_q.size(), 8);
    p_rvld = 100;
    repeat (30) cycle();

    p_ardy = 0;
    repeat (8) cycle();
    p_ardy = 100;
    repeat (20) cycle();

    for (int ph = 0; ph < 20; ph++) begin
      p_arv  = $urandom_range(20, 100); p_ardy = $urandom_range(10, 100);
      p_rvld = $urandom_range(10, 100); p_rrdy = $urandom_range(10, 100);
      repeat (100) cycle();
    end
    drain("random_drain");

    dir_q.push_back('{id: 5'd9, addr: 32'h0000_2000, burst: 2'd1, len: 3'd3, size: 3'd2});
    p_rrdy = 50;
    for (int i = 0; i < 80 && !(outst_q.size() > 0 && m_beat == 1); i++) cycle();
    check("mid_burst_reached", m_beat, 1);
    @(posedge ACLK_i);
    #3;
    ARESETn_i = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    clear_model();
    @(negedge ACLK_i);
    @(negedge ACLK_i);
    ARESETn_i = 1'b1;

    dir_q.push_back('{id: 5'd3, addr: 32'h4000_0000, burst: 2'd1, len: 3'd0, size: 3'd2});
    repeat (6) cycle();
    drain("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
